// File: rtl/pipe_pkg.sv
// Shared definitions for the memory stage: bus layouts, load type encodings,
// exception codes and the response-tracking state encoding.
package pipe_pkg;

    localparam int EXM_W      = 240;
    localparam int MWB_W      = 232;
    localparam int MID_W      = 54;
    localparam int CSR_NUM_W  = 14;
    localparam int MEM_TYPE_W = 4;

    // Execute-to-memory layout: the write-back fields sit above the memory controls.
    localparam int EXM_LOW2_LSB  = 0;
    localparam int EXM_TYPE_LSB  = 2;
    localparam int EXM_STORE_BIT = 6;
    localparam int EXM_LOAD_BIT  = 7;
    localparam int EXM_WB_LSB    = 8;

    localparam logic [MEM_TYPE_W-1:0] MT_B  = 4'd0;
    localparam logic [MEM_TYPE_W-1:0] MT_H  = 4'd1;
    localparam logic [MEM_TYPE_W-1:0] MT_W  = 4'd2;
    localparam logic [MEM_TYPE_W-1:0] MT_BU = 4'd4;
    localparam logic [MEM_TYPE_W-1:0] MT_HU = 4'd5;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_PIL = 6'h01;
    localparam logic [5:0] ECODE_PIS = 6'h02;
    localparam logic [5:0] ECODE_PIF = 6'h03;
    localparam logic [5:0] ECODE_PME = 6'h04;
    localparam logic [5:0] ECODE_PPI = 6'h07;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0b;
    localparam logic [5:0] ECODE_BRK = 6'h0c;
    localparam logic [5:0] ECODE_INE = 6'h0d;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_HAVE_DATA,
        S_DISCARD
    } mem_state_e;

    typedef struct packed {
        logic                 gr_we;
        logic [4:0]           dest;
        logic [31:0]          pc;
        logic [31:0]          inst;
        logic [31:0]          result;
        logic                 csr_we;
        logic                 csr_re;
        logic [CSR_NUM_W-1:0] csr_num;
        logic [31:0]          csr_wmask;
        logic [31:0]          csr_wvalue;
        logic                 ertn;
        logic                 syscall;
        logic [31:0]          wrong_addr;
        logic                 ex;
        logic [8:0]           esubcode;
        logic [5:0]           ecode;
    } mem_wb_t;

    typedef struct packed {
        mem_wb_t               wb;
        logic                  load;
        logic                  store;
        logic [MEM_TYPE_W-1:0] mem_type;
        logic [1:0]            addr_low2;
    } ex_mem_t;

    typedef struct packed {
        logic                 bypass_vld;
        logic                 ld_stall;
        logic [4:0]           dest;
        logic [31:0]          result;
        logic                 csr_re;
        logic [CSR_NUM_W-1:0] csr_num;
    } mem_id_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte/half of a response word and
// sign- or zero-extends it to 32 bits; word loads pass straight through.
module mem_load_align
    import pipe_pkg::*;
(
    input  logic [31:0]           rdata,
    input  logic [MEM_TYPE_W-1:0] mem_type,
    input  logic [1:0]            addr_low2,
    output logic [31:0]           load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (addr_low2)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
    end

    assign half_sel = addr_low2[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        case (mem_type)
            MT_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            MT_BU:   load_data = {24'd0, byte_sel};
            MT_H:    load_data = {{16{half_sel[15]}}, half_sel};
            MT_HU:   load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for data-SRAM responses, aligns loads and
// hands results to write-back. Define MEM_LD_BYPASS_EN to bypass load data to decode.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int EX_MEM_W = EXM_W,
    parameter int MEM_WB_W = MWB_W,
    parameter int MEM_ID_W = MID_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ex_mem_valid,
    input  logic [EX_MEM_W-1:0] ex_mem_bus,
    output logic                mem_allowin,
    output logic                mem_wb_valid,
    input  logic                wb_allowin,
    output logic [MEM_WB_W-1:0] mem_wb_bus,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    input  logic                wb_ex,
    input  logic                ertn_flush,
    output logic                mem_ex,
    output logic                mem_ertn,
    output logic [MEM_ID_W-1:0] mem_id_bus
);

    ex_mem_t               ex_in;
    mem_wb_t               wb_q, wb_d;
    logic                  ld_q, ld_d;
    logic [MEM_TYPE_W-1:0] mtype_q, mtype_d;
    logic [1:0]            low2_q, low2_d;
    logic                  mem_valid_q, mem_valid_d;
    mem_state_e            state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [31:0]           rdata_buf_q, rdata_buf_d;

    logic        flush;
    logic        capture;
    logic        req_issued;
    logic        cnt_inc;
    logic        ld_beat;
    logic        mem_ready_go;
    logic        data_avail;
    logic [31:0] ld_raw;
    logic [31:0] ld_data;
    logic [31:0] final_result;
    logic [31:0] id_result;
    mem_wb_t     wb_out;
    mem_id_t     id_out;

    assign ex_in      = ex_mem_bus;
    assign flush      = wb_ex | ertn_flush;
    assign req_issued = (ex_in.load | ex_in.store) & ~ex_in.wb.ex;

    // A waiting load is always the youngest outstanding request, so its own beat
    // is the one that arrives when it is the only request left in flight.
    assign ld_beat = data_sram_data_ok & (cnt_q == 2'd1);

    always_comb begin
        unique case (state_q)
            S_IDLE, S_HAVE_DATA: mem_ready_go = 1'b1;
            S_WAIT_DATA:         mem_ready_go = ld_beat;
            default:             mem_ready_go = 1'b0;
        endcase
    end

    assign mem_allowin  = (state_q != S_DISCARD) &
                          (~mem_valid_q | (mem_ready_go & wb_allowin));
    assign capture      = ex_mem_valid & mem_allowin;
    assign cnt_inc      = capture & req_issued;
    assign mem_wb_valid = mem_valid_q & mem_ready_go;

    always_comb begin
        mem_valid_d = mem_valid_q;
        wb_d        = wb_q;
        ld_d        = ld_q;
        mtype_d     = mtype_q;
        low2_d      = low2_q;
        if (capture) begin
            wb_d    = ex_in.wb;
            ld_d    = ex_in.load;
            mtype_d = ex_in.mem_type;
            low2_d  = ex_in.addr_low2;
        end
        if (flush) begin
            mem_valid_d = 1'b0;
        end else if (mem_allowin) begin
            mem_valid_d = ex_mem_valid;
        end
    end

    always_comb begin
        unique case ({cnt_inc, data_sram_data_ok})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        rdata_buf_d = rdata_buf_q;
        if ((state_q == S_WAIT_DATA) && ld_beat && !wb_allowin && !flush) begin
            rdata_buf_d = data_sram_rdata;
        end
    end

    // Capture of a new load overrides the retiring state; a flush in the same
    // cycle sends that load straight to DISCARD so its beat is still consumed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_WAIT_DATA: begin
                if (flush) begin
                    state_d = ld_beat ? S_IDLE : S_DISCARD;
                end else if (ld_beat) begin
                    state_d = wb_allowin ? S_IDLE : S_HAVE_DATA;
                end
            end
            S_HAVE_DATA: begin
                if (flush || wb_allowin) begin
                    state_d = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (ld_beat) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (cnt_inc && ex_in.load) begin
            state_d = flush ? S_DISCARD : S_WAIT_DATA;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_q <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            wb_q        <= '0;
            ld_q        <= 1'b0;
            mtype_q     <= '0;
            low2_q      <= 2'd0;
            rdata_buf_q <= 32'd0;
        end else begin
            mem_valid_q <= mem_valid_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wb_q        <= wb_d;
            ld_q        <= ld_d;
            mtype_q     <= mtype_d;
            low2_q      <= low2_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    assert property (@(posedge clk) disable iff (!resetn) cnt_q != 2'd3);

    assign ld_raw = (state_q == S_HAVE_DATA) ? rdata_buf_q : data_sram_rdata;

    mem_load_align u_load_align (
        .rdata     (ld_raw),
        .mem_type  (mtype_q),
        .addr_low2 (low2_q),
        .load_data (ld_data)
    );

    assign final_result = (ld_q & ~wb_q.ex) ? ld_data : wb_q.result;

`ifdef MEM_LD_BYPASS_EN
    assign data_avail = (state_q == S_HAVE_DATA) | ((state_q == S_WAIT_DATA) & ld_beat);
    assign id_result  = final_result;
`else
    // Load data never leaves towards decode from here, keeping rdata off that path.
    assign data_avail = 1'b0;
    assign id_result  = wb_q.result;
`endif

    always_comb begin
        wb_out        = wb_q;
        wb_out.result = final_result;
    end

    always_comb begin
        id_out            = '0;
        id_out.bypass_vld = mem_valid_q & wb_q.gr_we & ~wb_q.ex & (ld_q ? data_avail : 1'b1);
        id_out.ld_stall   = mem_valid_q & ld_q & ~data_avail;
        id_out.dest       = wb_q.dest;
        id_out.result     = id_result;
        id_out.csr_re     = mem_valid_q & wb_q.csr_re;
        id_out.csr_num    = wb_q.csr_num;
    end

    assign mem_wb_bus = wb_out;
    assign mem_id_bus = id_out;
    assign mem_ex     = mem_valid_q & wb_q.ex;
    assign mem_ertn   = mem_valid_q & wb_q.ertn;

endmodule
